// File: rtl/replay_packet_distributor.sv
// Broadcasts decoded replay packets in lock-step onto all per-channel replay buses.
// Issue is gated on the OR of every channel's almost-full, so all channels see identical loge ordering.
module replay_packet_distributor #(
    parameter int NUM_CHANNELS     = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int LOGE_CHANNEL_CNT = 6,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_CHANNELS-1:0]            in_logb_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_logb_data,
    input  logic [LOGE_CHANNEL_CNT-1:0]        in_loge_valid,
    input  logic [NUM_CHANNELS:0]              ch_almful,
    output logic                               out_valid,
    output logic [NUM_CHANNELS-1:0]            out_logb_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_logb_data,
    output logic [LOGE_CHANNEL_CNT-1:0]        out_loge_valid,
    output logic [CNT_WIDTH-1:0]               pkt_cnt,
    output logic [CNT_WIDTH-1:0]               stall_cnt,
    output logic [CNT_WIDTH-1:0]               drop_cnt
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                            state;
    logic [NUM_CHANNELS-1:0]           h_logb_valid;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] h_logb_data;
    logic [LOGE_CHANNEL_CNT-1:0]       h_loge_valid;

    logic any_almful;
    logic issue;
    logic accept;
    logic noop;
    logic load;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign any_almful = |ch_almful;
    assign issue      = (state == HELD) && !any_almful;
    // Held low during reset so nothing is accepted while the pipe is being cleared.
    assign in_ready   = !rst && ((state == EMPTY) || issue);
    assign accept     = in_valid && in_ready;
    assign noop       = accept && (in_logb_valid == '0) && (in_loge_valid == '0);
    assign load       = accept && !noop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            h_logb_valid   <= '0;
            h_logb_data    <= '0;
            h_loge_valid   <= '0;
            out_valid      <= 1'b0;
            out_logb_valid <= '0;
            out_logb_data  <= '0;
            out_loge_valid <= '0;
            pkt_cnt        <= '0;
            stall_cnt      <= '0;
            drop_cnt       <= '0;
        end else begin
            out_valid <= issue;
            if (issue) begin
                out_logb_valid <= h_logb_valid;
                out_logb_data  <= h_logb_data;
                out_loge_valid <= h_loge_valid;
                pkt_cnt        <= sat_inc(pkt_cnt);
            end
            if ((state == HELD) && any_almful) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (noop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            // A load in the same cycle as issue replaces the packet with no bubble.
            if (load) begin
                state        <= HELD;
                h_logb_valid <= in_logb_valid;
                h_logb_data  <= in_logb_data;
                h_loge_valid <= in_loge_valid;
            end else if (issue) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_replay_packet_distributor.sv
// Randomized and directed bench for replay_packet_distributor against a packet-queue reference model.
module tb_replay_packet_distributor;

    localparam int NC  = 4;
    localparam int DW  = 64;
    localparam int LC  = 6;
    localparam int CW  = 32;
    localparam int BW  = NC*DW;

    typedef struct {
        logic [NC-1:0] lv;
        logic [BW-1:0] ld;
        logic [LC-1:0] le;
    } pkt_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NC-1:0] in_logb_valid;
    logic [BW-1:0] in_logb_data;
    logic [LC-1:0] in_loge_valid;
    logic [NC:0]   ch_almful;
    logic          out_valid;
    logic [NC-1:0] out_logb_valid;
    logic [BW-1:0] out_logb_data;
    logic [LC-1:0] out_loge_valid;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] drop_cnt;

    replay_packet_distributor #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .LOGE_CHANNEL_CNT(LC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_logb_valid(in_logb_valid), .in_logb_data(in_logb_data),
        .in_loge_valid(in_loge_valid), .ch_almful(ch_almful),
        .out_valid(out_valid), .out_logb_valid(out_logb_valid),
        .out_logb_data(out_logb_data), .out_loge_valid(out_loge_valid),
        .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    // Reference: accepted-but-not-yet-broadcast packets, last broadcast packet, and event counts.
    pkt_t pending[$];
    pkt_t lastOut;
    int   expPkt;
    int   expStall;
    int   expDrop;
    int   strobeRun;

    task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        pending.delete();
        lastOut.lv = '0;
        lastOut.ld = '0;
        lastOut.le = '0;
        expPkt   = 0;
        expStall = 0;
        expDrop  = 0;
        strobeRun = 0;
    endtask

    // Drives one cycle of inputs, predicts the outcome and checks everything visible after the edge.
    task automatic applyStimulus(input logic v, input logic [NC-1:0] lv, input logic [BW-1:0] ld,
                                 input logic [LC-1:0] le, input logic [NC:0] alm);
        bit   held, blocked, canIssue, canTake, take, isNoop;
        pkt_t p;
        in_valid      = v;
        in_logb_valid = lv;
        in_logb_data  = ld;
        in_loge_valid = le;
        ch_almful     = alm;
        #1;
        held     = (pending.size() != 0);
        blocked  = (alm != '0);
        canIssue = held && !blocked;
        canTake  = !held || canIssue;
        checkOutput("in_ready", BW'(in_ready), BW'(canTake));
        take   = v && canTake;
        isNoop = take && (lv == '0) && (le == '0);
        @(posedge clk);
        if (canIssue) begin
            lastOut = pending.pop_front();
            expPkt++;
            strobeRun++;
        end else begin
            strobeRun = 0;
        end
        if (held && blocked) expStall++;
        if (isNoop) expDrop++;
        if (take && !isNoop) begin
            p.lv = lv; p.ld = ld; p.le = le;
            pending.push_back(p);
        end
        @(negedge clk);
        checkOutput("out_valid",      BW'(out_valid),      BW'(canIssue));
        checkOutput("out_logb_valid", BW'(out_logb_valid), BW'(lastOut.lv));
        checkOutput("out_logb_data",  out_logb_data,       lastOut.ld);
        checkOutput("out_loge_valid", BW'(out_loge_valid), BW'(lastOut.le));
        checkOutput("pkt_cnt",        BW'(pkt_cnt),        BW'(expPkt));
        checkOutput("stall_cnt",      BW'(stall_cnt),      BW'(expStall));
        checkOutput("drop_cnt",       BW'(drop_cnt),       BW'(expDrop));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0);
    endtask

    // Asserts reset asynchronously between edges and checks the immediate clear and the release.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", BW'(out_valid), '0);
        checkOutput("rst_pkt_cnt",   BW'(pkt_cnt),   '0);
        checkOutput("rst_stall_cnt", BW'(stall_cnt), '0);
        checkOutput("rst_drop_cnt",  BW'(drop_cnt),  '0);
        checkOutput("rst_in_ready",  BW'(in_ready),  '0);
        checkOutput("rst_out_data",  out_logb_data,  '0);
        clearModel();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready", BW'(in_ready), BW'(1));
    endtask

    function automatic logic [BW-1:0] randData();
        logic [BW-1:0] d;
        for (int i = 0; i < BW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [BW-1:0] d;
        int            startPkt;
        rst = 1'b1;
        in_valid = 1'b0; in_logb_valid = '0; in_logb_data = '0; in_loge_valid = '0; ch_almful = '0;
        clearModel();
        @(negedge clk);
        @(negedge clk);
        doReset();

        // Single packet with payload in slot 1.
        d = '0;
        d[1*DW +: DW] = 64'hDEAD_BEEF;
        applyStimulus(1'b1, 4'b0010, d, 6'b000010, '0);
        idle(2);
        checkOutput("single_slot1", BW'(out_logb_data[1*DW +: DW]), BW'(64'hDEAD_BEEF));
        checkOutput("single_pkt_cnt", BW'(pkt_cnt), BW'(1));

        // Eight back-to-back packets must stream with one strobe per cycle.
        startPkt = expPkt;
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, NC'(i + 1), randData(), LC'(i), '0);
        idle(1);
        checkOutput("b2b_strobe_run", BW'(strobeRun), BW'(8));
        checkOutput("b2b_pkt_delta",  BW'(expPkt - startPkt), BW'(8));
        idle(1);

        // Stall five cycles on channel 2, with a new packet waiting when almful falls.
        applyStimulus(1'b1, 4'b0101, randData(), 6'b100001, '0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 4'b1000, randData(), 6'b000100, 5'b00100);
        checkOutput("stall_cnt_5", BW'(stall_cnt), BW'(5));
        applyStimulus(1'b1, 4'b1000, randData(), 6'b000100, '0);
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("stall_release_run", BW'(strobeRun), BW'(2));
        idle(1);

        // No-op sandwiched between two real packets.
        applyStimulus(1'b1, 4'b0001, randData(), 6'b000001, '0);
        applyStimulus(1'b1, '0, randData(), '0, '0);
        applyStimulus(1'b1, 4'b0010, randData(), 6'b000010, '0);
        idle(2);
        checkOutput("noop_drop_cnt", BW'(drop_cnt), BW'(1));

        // Reset while holding a stalled packet; it must never appear afterwards.
        applyStimulus(1'b1, 4'b1111, randData(), 6'b111111, '0);
        applyStimulus(1'b0, '0, '0, '0, 5'b10000);
        applyStimulus(1'b0, '0, '0, '0, 5'b10000);
        doReset();
        idle(3);

        // Randomized traffic with occasional no-ops and backpressure.
        for (int i = 0; i < 400; i++) begin
            logic          v;
            logic [NC-1:0] lv;
            logic [LC-1:0] le;
            logic [NC:0]   alm;
            v   = ($urandom_range(0, 3) != 0);
            lv  = ($urandom_range(0, 3) == 0) ? '0 : NC'($urandom);
            le  = ($urandom_range(0, 3) == 0) ? '0 : LC'($urandom);
            alm = ($urandom_range(0, 3) == 0) ? (NC+1)'($urandom) : '0;
            applyStimulus(v, lv, randData(), le, alm);
        end
        idle(3);
        checkOutput("final_queue_empty", BW'(pending.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/replay_packet_distributor.md
Name: replay_packet_distributor

Overview:
Upstream neighbour of the per-channel valid/ready replayers. It takes fully decoded replay packets (one per trace record) from the decoder tree output and broadcasts them, in lock-step, onto the per-channel replay buses. It gates issue on the OR of all channels' almost-full, so every channel sees every loge_valid vector in the same order. It provides replay progress and stall counters for debug.

Parameters:
NUM_CHANNELS, 4, number of valid-replay channels fed (each owns one logb slot)
DATA_WIDTH, 64, per-channel logb payload width (uniform across channels)
LOGE_CHANNEL_CNT, 6, width of loge_valid vector (all tracked channels, incl. ready-only)
CNT_WIDTH, 32, width of debug counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  decoded packet valid
in_ready  output  1  packet accepted when in_valid && in_ready
in_logb_valid  input  NUM_CHANNELS  per-channel logb present bits
in_logb_data  input  NUM_CHANNELS*DATA_WIDTH  per-channel logb payload, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
in_loge_valid  input  LOGE_CHANNEL_CNT  loge bitmap of the packet
ch_almful  input  NUM_CHANNELS+1  almful from each valid replayer plus bit NUM_CHANNELS = OR of ready replayers
out_valid  output  1  single-cycle broadcast strobe (replay-bus in_valid, common to all channels)
out_logb_valid  output  NUM_CHANNELS  registered copy of in_logb_valid
out_logb_data  output  NUM_CHANNELS*DATA_WIDTH  registered copy of in_logb_data
out_loge_valid  output  LOGE_CHANNEL_CNT  registered copy of in_loge_valid
pkt_cnt  output  CNT_WIDTH  packets issued (saturating)
stall_cnt  output  CNT_WIDTH  cycles a packet is held with any almful set (saturating)
drop_cnt  output  CNT_WIDTH  no-op packets dropped (saturating)

Behaviour:
- Reset is asynchronous and active-high. The clock is clk and the reset is rst. On reset: hold register empty, out_valid=0, out_* data=0, all counters=0, in_ready=0 while rst is high and 1 in the first cycle after release.
- Hold register H: {valid, logb_valid, logb_data, loge_valid}.
- any_almful = |ch_almful. This is a combinational use of the registered almful from the channel pipes.
- issue = H.valid && !any_almful.
- in_ready = !H.valid || issue. This allows 1 packet/cycle throughput when there is no backpressure.
- On accept (in_valid && in_ready): if in_logb_valid==0 and in_loge_valid==0 the packet is a no-op. A no-op is dropped: H is not loaded (H.valid is cleared if issue) and drop_cnt increments. Otherwise H loads the packet.
- On issue: out_valid=1 in the next cycle, with out_* set to the H contents. Otherwise out_valid=0 and out_* hold their last values.
- Latency: a packet accepted at edge t issues at earliest cycle t+1, and out_valid is high after edge t+1, which is 2 cycles accept-to-strobe.
- States: EMPTY (H.valid=0) and HELD (H.valid=1).
  - EMPTY->HELD on a non-no-op accept.
  - HELD->EMPTY on issue without a concurrent non-no-op accept.
  - HELD->HELD on issue with a concurrent accept (replace), or on stall.
- Stall: while HELD and any_almful, the packet is held indefinitely, in_ready=0, and stall_cnt increments each cycle.
- The almful threshold downstream covers the pipe depth, so issue never checks per-channel occupancy beyond almful.
- A single strobe goes to all channels: every channel receives every packet, including packets whose logb bit for that channel is 0. This keeps the loge ordering identical everywhere. The block never splits or reorders packets.
- Counters saturate at all-ones and do not wrap. pkt_cnt increments on issue.
- Simultaneous almful deassert and a new in_valid in the same cycle: H issues and reloads in that cycle, with no bubble.
- Reset mid-HELD: the held packet is discarded and out_valid is forced to 0 immediately (async).
- Data inputs are ignored when in_valid=0. No X propagates to outputs after reset.

Test Plan:
- Single packet, logb_valid=4'b0010, data slot1=0xDEAD_BEEF, loge=6'b000010, almful=0 -> out_valid pulses once 2 cycles after accept, out_logb_data slot1=0xDEAD_BEEF, pkt_cnt=1.
- 8 back-to-back packets, no almful -> in_ready stays 1, 8 consecutive out_valid cycles in order, pkt_cnt=8, stall_cnt=0.
- Hold ch_almful[2]=1 for 5 cycles with a packet in H -> in_ready=0 and no out_valid for 5 cycles, stall_cnt=5; on release the packet issues next cycle.
- No-op packet (logb=0, loge=0) between two real packets -> only 2 out_valid strobes, drop_cnt=1, no bubble added.
- almful falls in the same cycle as a new in_valid -> held packet issues and the new one loads; out_valid on consecutive cycles.
- Assert rst while HELD and stalled -> out_valid=0 and counters=0 immediately; after release in_ready=1 and the discarded packet is never emitted.
